// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the seven-segment scan driver.
// Segment bit positions, hex glyphs and a polarity helper.
package seg7_pkg;

   localparam int SEG_A  = 7;
   localparam int SEG_B  = 6;
   localparam int SEG_C  = 5;
   localparam int SEG_D  = 4;
   localparam int SEG_E  = 3;
   localparam int SEG_F  = 2;
   localparam int SEG_G  = 1;
   localparam int SEG_DP = 0;

   // Glyphs for hex digits 0..F, {a,b,c,d,e,f,g,dp}
   localparam logic [7:0] HEX_SEG [16] = '{
      8'hFC, 8'h60, 8'hDA, 8'hF2,
      8'h66, 8'hB6, 8'hBE, 8'hE0,
      8'hFE, 8'hF6, 8'hEE, 8'h3E,
      8'h9C, 8'h7A, 8'h9E, 8'h8E
   };

   function automatic logic [7:0] apply_pol(
      input logic [7:0] v,
      input logic       inv
   );
      return inv ? ~v : v;
   endfunction

endpackage

// File: rtl/seg7_scan_timer.sv
// Slot counter, digit index, frame pulse and per-slot brightness gate.
// Ports: clock, reset_n, brightness in; idx, slot_on, frame_tick_pre out.
module seg7_scan_timer
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS  = 4,
   parameter int SCAN_DIV    = 1024,
   parameter int DEAD        = 2,
   parameter int BRIGHT_BITS = 3,
   parameter int AW          = 2
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic [BRIGHT_BITS-1:0] brightness,
   output logic [AW-1:0]          idx,
   output logic                   slot_on,
   output logic                   frame_tick_pre
);

   localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
   localparam logic [AW-1:0] IDX_LAST = AW'(NUM_DIGITS - 1);

   logic [CW-1:0]          cnt;
   logic [BRIGHT_BITS-1:0] bright_q;
   logic [BRIGHT_BITS-1:0] bright_cur;
   logic [31:0]            on_lim;
   logic                   cnt_end;

   assign cnt_end = (cnt == CNT_LAST);

   // The code is captured at cnt=0; use the live value on that
   // very clock so the first slot cycle already honours it.
   assign bright_cur = (cnt == '0) ? brightness : bright_q;

   assign on_lim = ((32'(bright_cur) + 32'd1) * 32'(SCAN_DIV))
                   >> BRIGHT_BITS;

   assign slot_on = (32'(cnt) >= 32'(DEAD)) &&
                    (32'(cnt) < on_lim);

   assign frame_tick_pre = cnt_end && (idx == IDX_LAST);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt      <= '0;
         idx      <= '0;
         bright_q <= '0;
      end else begin
         if (cnt == '0) begin
            bright_q <= brightness;
         end
         if (cnt_end) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed seven-segment driver with shadow/active registers.
// Ports: write/commit handshake, blank_en, brightness; digit_out, seg_out, led, frame_tick.
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS       = 4,
   parameter int SCAN_DIV         = 1024,
   parameter int DEAD             = 2,
   parameter int BRIGHT_BITS      = 3,
   parameter int DIGIT_ACTIVE_LOW = 1,
   parameter int SEG_ACTIVE_LOW   = 0,
   localparam int AW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   wr_valid,
   output logic                   wr_ready,
   input  logic [AW-1:0]          wr_addr,
   input  logic [7:0]             wr_data,
   input  logic                   wr_commit,
   input  logic                   blank_en,
   input  logic [BRIGHT_BITS-1:0] brightness,
   output logic [NUM_DIGITS-1:0]  digit_out,
   output logic [7:0]             seg_out,
   output logic [7:0]             led,
   output logic                   frame_tick
);

   localparam logic DIG_INV = (DIGIT_ACTIVE_LOW != 0);
   localparam logic SEG_INV = (SEG_ACTIVE_LOW != 0);

   logic [7:0] shadow [NUM_DIGITS];
   logic [7:0] active [NUM_DIGITS];
   logic       pending;

   logic [AW-1:0]         idx;
   logic                  slot_on;
   logic                  ft_pre;
   logic                  wr_acc;
   logic                  cm_acc;
   logic                  lit;
   logic [7:0]            cur_data;
   logic [NUM_DIGITS-1:0] dig_vec;
   logic [7:0]            seg_pol;

   seg7_scan_timer #(
      .NUM_DIGITS  (NUM_DIGITS),
      .SCAN_DIV    (SCAN_DIV),
      .DEAD        (DEAD),
      .BRIGHT_BITS (BRIGHT_BITS),
      .AW          (AW)
   ) u_timer (
      .clock          (clock),
      .reset_n        (reset_n),
      .brightness     (brightness),
      .idx            (idx),
      .slot_on        (slot_on),
      .frame_tick_pre (ft_pre)
   );

   // wr_ready is low whenever a commit is pending, which
   // masks both writes and further commits.
   assign wr_acc = wr_valid && wr_ready;
   assign cm_acc = wr_commit && wr_ready;
   assign lit    = slot_on && !blank_en;

   always_comb begin
      cur_data = '0;
      dig_vec  = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx == i[AW-1:0]) begin
            cur_data   = active[i];
            dig_vec[i] = lit;
         end
      end
   end

   assign seg_pol = apply_pol(lit ? cur_data : 8'h00, SEG_INV);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pending  <= 1'b0;
         wr_ready <= 1'b0;
         for (int i = 0; i < NUM_DIGITS; i++) begin
            shadow[i] <= '0;
            active[i] <= '0;
         end
      end else begin
         // Out-of-range addresses match no entry and drop out.
         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (wr_acc && wr_addr == i[AW-1:0]) begin
               shadow[i] <= wr_data;
            end
         end
         if (ft_pre && pending) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
               active[i] <= shadow[i];
            end
            pending <= 1'b0;
         end else if (cm_acc) begin
            pending <= 1'b1;
         end
         // Follows pending with one clock lag, so ready returns
         // one clock after the copy.
         wr_ready <= cm_acc ? 1'b0 : !pending;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         digit_out  <= DIG_INV ? '1 : '0;
         seg_out    <= SEG_INV ? 8'hFF : 8'h00;
         led        <= '0;
         frame_tick <= 1'b0;
      end else begin
         digit_out  <= DIG_INV ? ~dig_vec : dig_vec;
         seg_out    <= seg_pol;
         led        <= cur_data;
         frame_tick <= ft_pre;
      end
   end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (4-digit and 3-digit builds).
// Scoreboard queue of predicted output bundles, popped each clock.
module tb_seg7_scan_driver;
   import seg7_pkg::*;

   typedef struct packed {
      logic [3:0] dig;
      logic [7:0] seg;
      logic [7:0] led;
      logic       ft;
      logic       rdy;
   } obs_t;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       wr_valid = 1'b0;
   logic [1:0] wr_addr = '0;
   logic [7:0] wr_data = '0;
   logic       wr_commit = 1'b0;
   logic       blank_en = 1'b0;
   logic [1:0] brightness = '0;

   logic       wr_ready;
   logic [3:0] digit_out;
   logic [7:0] seg_out;
   logic [7:0] led;
   logic       frame_tick;

   logic       wr_ready3;
   logic [2:0] digit_out3;
   logic [7:0] seg_out3;
   logic [7:0] led3;
   logic       frame_tick3;

   int checks = 0;
   int errors = 0;

   int         tcnt;
   logic [7:0] m_sh [4];
   logic [7:0] m_act [4];
   logic       m_pend;
   logic       m_rdy;
   logic [1:0] m_bq;
   obs_t       q[$];

   always #5 clock = ~clock;

   seg7_scan_driver #(
      .NUM_DIGITS (4), .SCAN_DIV (8), .DEAD (1), .BRIGHT_BITS (2),
      .DIGIT_ACTIVE_LOW (1), .SEG_ACTIVE_LOW (0)
   ) dut (
      .clock (clock), .reset_n (reset_n),
      .wr_valid (wr_valid), .wr_ready (wr_ready),
      .wr_addr (wr_addr), .wr_data (wr_data),
      .wr_commit (wr_commit), .blank_en (blank_en),
      .brightness (brightness), .digit_out (digit_out),
      .seg_out (seg_out), .led (led), .frame_tick (frame_tick)
   );

   seg7_scan_driver #(
      .NUM_DIGITS (3), .SCAN_DIV (8), .DEAD (1), .BRIGHT_BITS (2),
      .DIGIT_ACTIVE_LOW (1), .SEG_ACTIVE_LOW (0)
   ) dut3 (
      .clock (clock), .reset_n (reset_n),
      .wr_valid (wr_valid), .wr_ready (wr_ready3),
      .wr_addr (wr_addr), .wr_data (wr_data),
      .wr_commit (wr_commit), .blank_en (blank_en),
      .brightness (brightness), .digit_out (digit_out3),
      .seg_out (seg_out3), .led (led3), .frame_tick (frame_tick3)
   );

   // Predict the outputs produced by the coming rising edge from
   // the edge count since reset and the inputs now applied.
   task automatic model_step();
      int c, i, lim;
      logic [1:0] b;
      logic on, wa, ca, nrdy;
      obs_t e;
      c = tcnt % 8;
      i = (tcnt / 8) % 4;
      b = (c == 0) ? brightness : m_bq;
      if (c == 0) m_bq = brightness;
      lim = ((int'(b) + 1) * 8) >> 2;
      on = (c >= 1) && (c < lim) && !blank_en;
      e.dig = 4'b1111;
      if (on) e.dig[i] = 1'b0;
      e.seg = on ? m_act[i] : 8'h00;
      e.led = m_act[i];
      e.ft = (c == 7) && (i == 3);
      wa = wr_valid && m_rdy;
      ca = wr_commit && m_rdy;
      nrdy = ca ? 1'b0 : !m_pend;
      e.rdy = nrdy;
      if (wa) m_sh[wr_addr] = wr_data;
      if (e.ft && m_pend) begin
         for (int j = 0; j < 4; j++) m_act[j] = m_sh[j];
         m_pend = 1'b0;
      end else if (ca) begin
         m_pend = 1'b1;
      end
      m_rdy = nrdy;
      tcnt++;
      q.push_back(e);
   endtask

   task automatic tick();
      model_step();
      @(posedge clock);
   endtask

   task automatic model_reset();
      tcnt = 0;
      m_pend = 1'b0;
      m_rdy = 1'b0;
      m_bq = '0;
      for (int j = 0; j < 4; j++) begin
         m_sh[j] = '0;
         m_act[j] = '0;
      end
      q.delete();
   endtask

   task automatic do_reset(input logic [1:0] b);
      @(negedge clock);
      reset_n = 1'b0;
      wr_valid = 1'b0;
      wr_commit = 1'b0;
      blank_en = 1'b0;
      brightness = b;
      #1;
      model_reset();
      @(negedge clock);
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      obs_t e, o;
      do_reset(2'd3);
      for (int k = 0; k < 20; k++) begin
         wr_valid = (k == 2);
         wr_commit = (k == 2);
         wr_addr = 2'd1;
         wr_data = 8'hAB;
         tick();
         @(negedge clock);
         e = q.pop_front();
         o = {digit_out, seg_out, led, frame_tick, wr_ready};
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL reset_pre k=%0d got %h want %h", k, o, e);
         end
      end
      reset_n = 1'b0;
      #1;
      o = {digit_out, seg_out, led, frame_tick, wr_ready};
      e = {4'b1111, 8'h00, 8'h00, 1'b0, 1'b0};
      checks++;
      if (o !== e) begin
         errors++;
         $display("FAIL reset_async got %h want %h", o, e);
      end
      checks++;
      if (digit_out3 !== 3'b111 || wr_ready3 !== 1'b0) begin
         errors++;
         $display("FAIL reset_async3 got %b/%b want 111/0",
                  digit_out3, wr_ready3);
      end
      model_reset();
      @(negedge clock);
      reset_n = 1'b1;
      for (int k = 0; k < 70; k++) begin
         tick();
         @(negedge clock);
         e = q.pop_front();
         o = {digit_out, seg_out, led, frame_tick, wr_ready};
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL reset_post k=%0d got %h want %h", k, o, e);
         end
      end
   endtask

   task automatic test_write_commit();
      obs_t e, o;
      int rise_k = -1;
      int ft_k = -1;
      logic seen = 1'b0;
      do_reset(2'd3);
      for (int k = 0; k < 80; k++) begin
         wr_valid = (k == 2);
         wr_addr = 2'd2;
         wr_data = HEX_SEG[0];
         wr_commit = (k == 4);
         tick();
         @(negedge clock);
         e = q.pop_front();
         o = {digit_out, seg_out, led, frame_tick, wr_ready};
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL write_commit k=%0d got %h want %h", k, o, e);
         end
         if (k > 4 && wr_ready && rise_k < 0) rise_k = k;
         if (frame_tick && ft_k < 0) ft_k = k;
         if (digit_out == 4'b1011 && seg_out == 8'hFC && led == 8'hFC)
            seen = 1'b1;
      end
      checks++;
      if (ft_k != 31 || rise_k != 32) begin
         errors++;
         $display("FAIL commit_ready ft=%0d rdy=%0d want 31/32",
                  ft_k, rise_k);
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL digit2_shown got 0 want 1");
      end
   endtask

   task automatic test_brightness();
      obs_t e, o;
      int on_cnt;
      int want [3] = '{4, 28, 22};
      for (int p = 0; p < 3; p++) begin
         do_reset(p == 1 ? 2'd3 : 2'd0);
         on_cnt = 0;
         for (int k = 0; k < 32; k++) begin
            if (p == 2 && k == 3) brightness = 2'd3;
            tick();
            @(negedge clock);
            e = q.pop_front();
            o = {digit_out, seg_out, led, frame_tick, wr_ready};
            checks++;
            if (o !== e) begin
               errors++;
               $display("FAIL bright%0d k=%0d got %h want %h",
                        p, k, o, e);
            end
            if (digit_out != 4'b1111) on_cnt++;
         end
         checks++;
         if (on_cnt != want[p]) begin
            errors++;
            $display("FAIL bright_duty%0d got %0d want %0d",
                     p, on_cnt, want[p]);
         end
      end
   endtask

   task automatic test_frame_blank();
      obs_t e, o;
      int ft_n = 0;
      int ft_a = -1;
      int ft_b = -1;
      do_reset(2'd3);
      for (int k = 0; k < 70; k++) begin
         blank_en = (k >= 43 && k < 50);
         tick();
         @(negedge clock);
         e = q.pop_front();
         o = {digit_out, seg_out, led, frame_tick, wr_ready};
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL frame_blank k=%0d got %h want %h", k, o, e);
         end
         if (frame_tick) begin
            ft_n++;
            if (ft_a < 0) ft_a = k;
            else ft_b = k;
         end
         if (k == 42 || k == 43) begin
            checks++;
            if (digit_out !== (k == 42 ? 4'b1101 : 4'b1111)) begin
               errors++;
               $display("FAIL blank_edge k=%0d got %b", k, digit_out);
            end
         end
      end
      checks++;
      if (ft_n != 2 || ft_a != 31 || ft_b - ft_a != 32) begin
         errors++;
         $display("FAIL frame_period got n=%0d at %0d,%0d want 2 at 31,63",
                  ft_n, ft_a, ft_b);
      end
   endtask

   task automatic test_same_cycle();
      obs_t e, o;
      do_reset(2'd3);
      for (int k = 0; k < 45; k++) begin
         wr_valid = (k == 2);
         wr_commit = (k == 2);
         wr_addr = 2'd0;
         wr_data = HEX_SEG[1];
         tick();
         @(negedge clock);
         e = q.pop_front();
         o = {digit_out, seg_out, led, frame_tick, wr_ready};
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL same_cycle k=%0d got %h want %h", k, o, e);
         end
         if (k == 34) begin
            checks++;
            if (digit_out !== 4'b1110 || seg_out !== 8'h60) begin
               errors++;
               $display("FAIL same_cycle_show got %b/%h want 1110/60",
                        digit_out, seg_out);
            end
         end
      end
   endtask

   task automatic test_bad_addr();
      obs_t e, o;
      int ft3 = 0;
      logic bad;
      do_reset(2'd3);
      for (int k = 0; k < 80; k++) begin
         wr_valid = (k == 2);
         wr_commit = (k == 2);
         wr_addr = 2'd3;
         wr_data = 8'hFF;
         tick();
         @(negedge clock);
         e = q.pop_front();
         o = {digit_out, seg_out, led, frame_tick, wr_ready};
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL bad_addr4 k=%0d got %h want %h", k, o, e);
         end
         bad = (led3 !== 8'h00) || (seg_out3 !== 8'h00) ||
               !(digit_out3 inside {3'b110, 3'b101, 3'b011, 3'b111});
         checks++;
         if (bad) begin
            errors++;
            $display("FAIL bad_addr3 k=%0d got dig=%b seg=%h led=%h",
                     k, digit_out3, seg_out3, led3);
         end
         if (frame_tick3) ft3++;
      end
      checks++;
      if (ft3 != 3 || wr_ready3 !== 1'b1) begin
         errors++;
         $display("FAIL bad_addr3_frame got ft=%0d rdy=%b want 3/1",
                  ft3, wr_ready3);
      end
   endtask

   task automatic test_back_to_back();
      obs_t e, o;
      do_reset(2'd2);
      for (int k = 0; k < 110; k++) begin
         wr_valid = (k >= 2 && k <= 8) || k == 40;
         wr_addr = (k == 40) ? 2'd1 : 2'((k - 2) % 4);
         wr_data = 8'($urandom_range(0, 255));
         wr_commit = (k == 5) || (k == 41);
         tick();
         @(negedge clock);
         e = q.pop_front();
         o = {digit_out, seg_out, led, frame_tick, wr_ready};
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL back_to_back k=%0d got %h want %h", k, o, e);
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_write_commit();
      test_brightness();
      test_frame_blank();
      test_same_cycle();
      test_bad_addr();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
